// File: rtl/lfrs_pkg.sv
// Shared definitions for the 5-bit lfrs generator and its stream checker.
package lfrs_pkg;

  // Generator reset state; its first emitted sample is 4'hf.
  localparam logic [4:0] LFRS_SEED = 5'h1f;

  // Checker acquisition/tracking states.
  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SEED,
    ST_VERIFY,
    ST_LOCK
  } chk_st_t;

  // One step of the generator recurrence; the sample is state bits [4:1].
  function automatic logic [4:0] lfrs_next(input logic [4:0] s);
    lfrs_next = {s[0],
                 s[4] ^ s[1],
                 s[3] ^ s[0],
                 s[2] ^ s[4] ^ s[1],
                 s[1] ^ s[3] ^ s[0]};
  endfunction

endpackage

// File: rtl/lfrs_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module lfrs_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Count up to all-ones and hold there until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && !(&cnt))   cnt <= cnt + ONE;
  end

endmodule

// File: rtl/lfrs_chk.sv
// Self-synchronising checker for the 4-bit lfrs sample stream: recovers the
// full generator state from two samples, verifies a run of predictions, then
// tracks the stream and reports mismatches while locked.
module lfrs_chk #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_THR = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_vld,
  input  logic [3:0]       din,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);
  import lfrs_pkg::*;

  // Terminal values for the 4-bit run counters (count is compared before +1).
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_THR - 1);

  chk_st_t    st;
  logic [3:0] shd;       // previous sample = candidate state bits [4:1]
  logic [4:0] exp_st;    // predicted generator state for the next sample
  logic [3:0] mcnt;      // matches seen in VERIFY
  logic [3:0] lcnt;      // consecutive mismatches in LOCK

  logic [4:0] cand;
  logic [4:0] cand_nxt;
  logic       seed_ok;
  logic       hit;
  logic       err_inc;

  // Candidate state: previous sample on top, and bit 0 is what the
  // generator shifted into bit 4 of the current sample.
  assign cand     = {shd, din[3]};
  assign cand_nxt = lfrs_next(cand);
  // All-zero is the generator's lock-up state, never a legal seed.
  assign seed_ok  = (cand != 5'd0) && (cand_nxt[3:1] == din[2:0]);
  assign hit      = (din == exp_st[4:1]);
  assign err_inc  = din_vld && (st == ST_LOCK) && !hit;

  // Acquisition / tracking FSM with registered lock and error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_SEARCH;
      shd       <= '0;
      exp_st    <= '0;
      mcnt      <= '0;
      lcnt      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (din_vld) begin
        case (st)
          ST_SEARCH: begin
            shd <= din;
            st  <= ST_SEED;
          end
          ST_SEED: begin
            if (seed_ok) begin
              // cand_nxt is the state that produced din; predict the one after.
              exp_st <= lfrs_next(cand_nxt);
              mcnt   <= '0;
              st     <= ST_VERIFY;
            end else begin
              shd <= din;
            end
          end
          ST_VERIFY: begin
            if (hit) begin
              exp_st <= lfrs_next(exp_st);
              mcnt   <= mcnt + 4'd1;
              if (mcnt == LOCK_LAST) begin
                st     <= ST_LOCK;
                locked <= 1'b1;
                lcnt   <= '0;
              end
            end else begin
              // A bad prediction means the seed was wrong; reseed from here.
              shd <= din;
              st  <= ST_SEED;
            end
          end
          ST_LOCK: begin
            // Prediction free-runs while locked so a corrupted sample never
            // pulls the checker off the true sequence.
            exp_st <= lfrs_next(exp_st);
            if (hit) begin
              lcnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (lcnt == LOSS_LAST) begin
                st     <= ST_SEARCH;
                locked <= 1'b0;
                lcnt   <= '0;
              end else begin
                lcnt <= lcnt + 4'd1;
              end
            end
          end
          default: st <= ST_SEARCH;
        endcase
      end
    end
  end

  lfrs_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .clr   (clr),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_lfrs_chk.sv
// Scoreboarded random/directed bench for lfrs_chk with a sample-level model.
module tb_lfrs_chk;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_THR = 3;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             din_vld = 1'b0;
  logic [3:0]       din = 4'h0;
  logic             clr = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;

  always #5 clk = ~clk;

  lfrs_chk #(.LOCK_CNT(LOCK_CNT), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_vld   (din_vld),
    .din       (din),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic             lk;
    logic             pl;
    logic [CNT_W-1:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Generator step written straight from the recurrence.
  function automatic logic [4:0] gen_step(input logic [4:0] s);
    logic [4:0] n;
    n[4] = s[0];
    n[3] = s[4] ^ s[1];
    n[2] = s[3] ^ s[0];
    n[1] = s[2] ^ s[4] ^ s[1];
    n[0] = s[1] ^ s[3] ^ s[0];
    return n;
  endfunction

  // ---------------- reference model (one call per valid sample) ----------
  // mode: 0 searching, 1 seeding, 2 verifying, 3 locked
  int         m_mode;
  logic [3:0] m_prev;
  logic [4:0] m_pred;
  int         m_good, m_loss, m_cnt;
  logic       m_pulse;

  function automatic void model_reset();
    m_mode = 0; m_prev = 4'h0; m_pred = 5'h0;
    m_good = 0; m_loss = 0; m_cnt = 0; m_pulse = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input logic [3:0] d, input logic c);
    logic       err;
    logic       found;
    logic [4:0] sv, nx, st_ok;
    err = 1'b0;
    m_pulse = 1'b0;
    if (v) begin
      case (m_mode)
        0: begin m_prev = d; m_mode = 1; end
        1: begin
          // Search every non-zero state that emits prev then d.
          found = 1'b0; st_ok = 5'h0;
          for (int s = 1; s < 32; s++) begin
            sv = 5'(s);
            nx = gen_step(sv);
            if (sv[4:1] == m_prev && nx[4:1] == d) begin found = 1'b1; st_ok = nx; end
          end
          if (found) begin m_pred = gen_step(st_ok); m_good = 0; m_mode = 2; end
          else m_prev = d;
        end
        2: begin
          if (d == m_pred[4:1]) begin
            m_good++;
            m_pred = gen_step(m_pred);
            if (m_good == LOCK_CNT) begin m_mode = 3; m_loss = 0; end
          end else begin
            m_prev = d; m_mode = 1;
          end
        end
        default: begin
          if (d != m_pred[4:1]) begin err = 1'b1; m_pulse = 1'b1; m_loss++; end
          else m_loss = 0;
          m_pred = gen_step(m_pred);
          if (m_loss == LOSS_THR) begin m_mode = 0; m_loss = 0; end
        end
      endcase
    end
    if (c) m_cnt = 0;
    else if (err && m_cnt < CNT_MAX) m_cnt++;
  endfunction

  // ---------------- driver ----------------
  logic [4:0] gen;

  task automatic step(input logic v, input logic [3:0] d, input logic c);
    exp_t e;
    @(negedge clk);
    din_vld = v; din = d; clr = c;
    if (!rst_n) model_reset();
    else model_step(v, d, c);
    e.lk = (m_mode == 3); e.pl = m_pulse; e.c = CNT_W'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic send(input logic [3:0] mask, input logic c);
    step(1'b1, gen[4:1] ^ mask, c);
    gen = gen_step(gen);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Asserts reset mid-cycle, checks the async clear, then releases it.
  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_pulse"},  32'(err_pulse), 32'd0);
    check({tag, "_cnt"},    32'(err_cnt), 32'd0);
    model_reset();
    step(1'b1, gen[4:1], 1'b0);   // lost while in reset
    step(1'b0, 4'h0, 1'b0);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("sb_locked", 32'(locked),    32'(e.lk));
      check("sb_pulse",  32'(err_pulse), 32'(e.pl));
      check("sb_cnt",    32'(err_cnt),   32'(e.c));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int nv;
    model_reset();
    gen = 5'h1f;
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_pulse",  32'(err_pulse), 32'd0);
    check("rst_cnt",    32'(err_cnt), 32'd0);
    step(1'b1, 4'hf, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    #1 rst_n = 1'b1;

    // Clean stream from the generator seed: lock after the 6th sample.
    for (int i = 0; i < 5; i++) send(4'h0, 1'b0);
    settle();
    check("acq_pre_lock", 32'(locked), 32'd0);
    send(4'h0, 1'b0);
    settle();
    check("acq_locked", 32'(locked), 32'd1);
    check("acq_cnt", 32'(err_cnt), 32'd0);

    // Single corrupted sample while locked.
    send(4'h0, 1'b0);
    send(4'h1, 1'b0);
    settle();
    check("one_err_pulse", 32'(err_pulse), 32'd1);
    check("one_err_cnt", 32'(err_cnt), 32'd1);
    check("one_err_locked", 32'(locked), 32'd1);
    send(4'h0, 1'b0);
    settle();
    check("one_err_recover", 32'(err_pulse), 32'd0);
    for (int i = 0; i < 3; i++) send(4'h0, 1'b0);

    // LOSS_THR consecutive errors drop lock, then relock on clean data.
    send(4'h8, 1'b0);
    send(4'h8, 1'b0);
    settle();
    check("loss_still_locked", 32'(locked), 32'd1);
    send(4'h8, 1'b0);
    settle();
    check("loss_unlocked", 32'(locked), 32'd0);
    check("loss_pulse", 32'(err_pulse), 32'd1);
    check("loss_cnt", 32'(err_cnt), 32'd4);
    for (int i = 0; i < 6; i++) send(4'h0, 1'b0);
    settle();
    check("relock", 32'(locked), 32'd1);

    // Random valid gaps: lock point counted in valid samples only.
    settle();
    async_reset("rst_a");
    gen = 5'($urandom_range(1, 31));
    nv = 0;
    for (int k = 0; k < 400 && nv < 6; k++) begin
      if ($urandom_range(0, 1) == 1) begin send(4'h0, 1'b0); nv++; end
      else step(1'b0, 4'($urandom), 1'b0);
    end
    settle();
    check("gap_locked", 32'(locked), 32'd1);
    check("gap_cnt", 32'(err_cnt), 32'd0);

    // All-zero input never locks.
    async_reset("rst_b");
    for (int i = 0; i < 20; i++) step(1'b1, 4'h0, 1'b0);
    settle();
    check("zero_locked", 32'(locked), 32'd0);

    // Saturation, clear-vs-increment, async reset mid-lock.
    gen = 5'($urandom_range(1, 31));
    for (int i = 0; i < 8; i++) send(4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      send(4'h2, 1'b0);
      send(4'h0, 1'b0);
    end
    settle();
    check("sat_cnt", 32'(err_cnt), 32'(CNT_MAX));
    check("sat_locked", 32'(locked), 32'd1);
    send(4'h2, 1'b1);
    settle();
    check("clr_wins_cnt", 32'(err_cnt), 32'd0);
    check("clr_wins_pulse", 32'(err_pulse), 32'd1);
    send(4'h0, 1'b0);
    send(4'h4, 1'b0);
    settle();
    check("pre_rst_pulse", 32'(err_pulse), 32'd1);
    async_reset("rst_lock");

    // Long random run: gaps, corruption, phase jumps, clears.
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] mask;
      logic       c;
      if ($urandom_range(0, 99) < 2) gen = 5'($urandom_range(1, 31));
      mask = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      c    = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 3) != 0) send(mask, c);
      else step(1'b0, 4'($urandom), c);
    end
    step(1'b0, 4'h0, 1'b0);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
